mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port a  input  XLEN  rs1 operand (dividend / multiplicand).
REQ-007 SHALL have port b  input  XLEN  rs2 operand (divisor / multiplier).
REQ-008 SHALL have port busy  output  1  high while a request is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port result  output  XLEN  registered result.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE.
REQ-012 SHALL leave IDLE only on start=1, registering op, a and b at that edge; later input changes SHALL be ignored.
REQ-013 SHALL ignore start in CALC and DONE; requests are neither queued nor accepted.
REQ-014 SHALL go IDLE->CALC on an accepted request, except for the fast-path cases in REQ-019 and REQ-020.
REQ-015 SHALL remain in CALC exactly XLEN cycles:
  - 5-bit step counter, 0..XLEN-1.
  - Multiply: one shift-add step per cycle.
  - Divide: one restoring shift-subtract step per cycle.
  - CALC->DONE when counter = XLEN-1.
REQ-016 SHALL hold DONE exactly one cycle, then go DONE->IDLE; a start sampled in that IDLE cycle SHALL be accepted.
REQ-017 SHALL assert busy in CALC and DONE, and deassert it in IDLE.
REQ-018 SHALL assert done only in DONE; normal latency is XLEN+1 cycles from the accepting edge to done high.
REQ-019 SHALL treat divide-by-zero (b=0, op 1xx) as fast path, IDLE->DONE directly (done one cycle after acceptance):
  - DIV/DIVU result = all ones.
  - REM/REMU result = a.
REQ-020 SHALL treat signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM) as fast path:
  - DIV result = 0x80000000.
  - REM result = 0.
REQ-021 SHALL compute the full 2*XLEN-bit product:
  - MUL returns the low half.
  - MULH returns the high half, signed x signed.
  - MULHSU returns the high half, signed a x unsigned b.
  - MULHU returns the high half, unsigned x unsigned.
REQ-022 SHALL handle signed division on magnitudes, then:
  - negate the quotient when the operand signs differ;
  - give the remainder the sign of the dividend.
REQ-023 SHALL update result only on entry to DONE, and hold it stable until the next DONE.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, force:
  - state IDLE;
  - busy=0, done=0, result=0;
  - step counter 0;
  - all internal operand and accumulator registers 0.
REQ-025 SHALL abort any operation in progress on reset with no done pulse; rst SHALL override start in the same cycle.

Structure
REQ-026 SHALL take the op encodings (REQ-005), the FSM state encoding and XLEN from the shared CPU package, also used by the decoder.
REQ-027 SHALL be a single module; the per-step add/subtract is inline logic with no sub-module.
REQ-028 SHALL share one XLEN+1-bit adder between multiply and divide steps.

Verification
REQ-029 SHALL cover MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 33 cycles after the accepting edge.
REQ-030 SHALL cover MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-031 SHALL cover DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
REQ-032 SHALL cover DIVU a=5, b=0 -> 0xFFFFFFFF, and REM a=5, b=0 -> 5, each with done one cycle after acceptance; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-033 SHALL cover start held high throughout: a second request is accepted only in the IDLE cycle after DONE, and operand changes during CALC do not alter the result.
REQ-034 SHALL cover rst asserted at CALC step 10 -> next cycle busy=0, done=0, result=0, with no done pulse; a fresh request then completes correctly.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared CPU package: datapath width, M-extension funct3 codes
// and the multiply/divide unit state encoding.
package mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle through a single shared adder.
module mdu #(
    parameter int XLEN = mdu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import mdu_pkg::*;

    localparam int CW = $clog2(XLEN);

    mdu_state_t state_q, state_d;

    logic [2:0]      op_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic            neg_q;
    logic            rneg_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] res_q;

    logic            sgn_a, sgn_b, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div0, ovf, fast;
    logic [XLEN-1:0] fast_res;
    logic            is_div, last;
    logic [XLEN:0]   add_x, add_y;
    logic            add_c;
    logic [XLEN+1:0] add_s;
    logic [XLEN-1:0] hi_n, lo_n;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] quo_s, rem_s;
    logic [XLEN-1:0] fin_res;

    // Operand conditioning and fast-path detection at acceptance
    always_comb begin
        sgn_a = (op == OP_MULH) || (op == OP_MULHSU) ||
                (op == OP_DIV)  || (op == OP_REM);
        sgn_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg = sgn_a & a[XLEN-1];
        b_neg = sgn_b & b[XLEN-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        div0  = op[2] && (b == '0);
        ovf   = ((op == OP_DIV) || (op == OP_REM)) &&
                (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        fast  = div0 || ovf;
        fast_res = '0;
        if (div0)
            fast_res = op[1] ? a : '1;
        else if (ovf)
            fast_res = op[1] ? '0 : a;
    end

    // One iteration step through the shared XLEN+1-bit adder
    always_comb begin
        is_div = op_q[2];
        last   = (cnt_q == CW'(XLEN-1));
        add_x  = is_div ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
        add_y  = is_div ? ~{1'b0, dvs_q}
               : (lo_q[0] ? {1'b0, dvs_q} : '0);
        add_c  = is_div;
        add_s  = {1'b0, add_x} + {1'b0, add_y} +
                 {{(XLEN+1){1'b0}}, add_c};
        if (is_div) begin
            hi_n = add_s[XLEN+1] ? add_s[XLEN-1:0] : add_x[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], add_s[XLEN+1]};
        end else begin
            hi_n = add_s[XLEN:1];
            lo_n = {add_s[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign fix-up and result selection after the final step
    always_comb begin
        prod    = {hi_n, lo_n};
        prod_s  = neg_q ? -prod : prod;
        quo_s   = neg_q ? -lo_n : lo_n;
        rem_s   = rneg_q ? -hi_n : hi_n;
        fin_res = '0;
        unique case (op_q)
            OP_MUL:                     fin_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                   fin_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            fin_res = quo_s;
            OP_REM, OP_REMU:            fin_res = rem_s;
            default:                    fin_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and status outputs
    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    state_d = fast ? S_DONE : S_CALC;
            end
            S_CALC: if (last) state_d = S_DONE;
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture, iteration registers and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            dvs_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            cnt_q  <= '0;
            res_q  <= '0;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                op_q   <= op;
                dvs_q  <= op[2] ? b_mag : a_mag;
                hi_q   <= '0;
                lo_q   <= op[2] ? a_mag : b_mag;
                neg_q  <= a_neg ^ b_neg;
                rneg_q <= a_neg;
                cnt_q  <= '0;
                if (fast)
                    res_q <= fast_res;
            end
        end else if (state_q == S_CALC) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= last ? '0 : cnt_q + 1'b1;
            if (last)
                res_q <= fin_res;
        end
    end

    assign result = res_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for the multiply/divide unit: a driver pushes
// expected results, a monitor pops them on every done pulse.
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    mdu dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint      sx;
        longint      sy;
        logic [63:0] p;
        int          ix;
        int          iy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ix = x;
        iy = y;
        case (f)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                return ix / iy;
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
                return ix % iy;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f,
                                   input logic [31:0] x,
                                   input logic [31:0] y);
        if (f[2] && y == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 &&
            y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic push_exp(input logic [2:0] f, input logic [31:0] x,
                            input logic [31:0] y);
        exp_t e;
        e.f   = f;
        e.res = model(f, x, y);
        e.acc = cyc;
        e.lat = latency(f, x, y);
        q.push_back(e);
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] x,
                         input logic [31:0] y);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: busy stuck, wanted idle");
        end
        start = 1'b1;
        op    = f;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        push_exp(f, x, y);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_done: result %h, expected none",
                         result);
            end else begin
                exp_t e;
                e = q.pop_front();
                check($sformatf("result_op%0d", e.f), result, e.res);
                check($sformatf("latency_op%0d", e.f),
                      32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    initial begin
        int acc_cyc[2];
        int n_acc;
        int guard;
        logic idle;

        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = 32'h0;
        b     = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;

        issue(3'd0, 32'd7, 32'hFFFF_FFFD);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2);
        issue(3'd5, 32'd100, 32'd7);
        issue(3'd7, 32'd100, 32'd7);
        issue(3'd5, 32'd5, 32'd0);
        issue(3'd6, 32'd5, 32'd0);
        issue(3'd4, 32'd5, 32'd0);
        issue(3'd7, 32'd9, 32'd0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        for (int i = 0; i < 60; i++)
            issue(3'($urandom_range(0, 7)), pick(), pick());

        n_acc = 0;
        guard = 0;
        while (n_acc < 2 && guard < 200) begin
            @(negedge clk);
            guard++;
            start = 1'b1;
            idle  = !busy;
            if (idle) begin
                op = (n_acc == 0) ? 3'd3 : 3'd4;
                a  = $urandom;
                b  = ($urandom | 32'd1) & 32'h7FFF_FFFF;
            end else begin
                op = 3'($urandom);
                a  = $urandom;
                b  = $urandom;
            end
            @(posedge clk);
            #1;
            if (idle) begin
                push_exp(op, a, b);
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
        end
        start = 1'b0;
        if (n_acc == 2)
            check("held_start_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd34);
        else
            check("held_start_accepts", 32'(n_acc), 32'd2);

        issue(3'd5, $urandom, ($urandom | 32'd1));
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        void'(q.pop_back());
        @(posedge clk);
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(3'd6, 32'hFFFF_FFF9, 32'd2);
        issue(3'd0, $urandom, $urandom);

        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d pending, expected 0",
                     q.size());
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_cmp, n_err);
        $finish;
    end

endmodule
